input_shift_register: RTL and testbench

//  Receive-side counterpart of output_shift_register: per-FSM input shift register (ISR).

---
 rtl/input_shift_register_pkg.sv | 29 ++
 rtl/input_shift_register_if.sv | 28 ++
 rtl/input_shift_register_isr_shift_merge.sv | 36 +++
 rtl/input_shift_register.sv | 167 ++++++++++++++++
 tb/tb_input_shift_register.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/input_shift_register_pkg.sv
// Shared definitions for the PIO receive path (ISR, RX fifo, test wrapper).
//   fifo_status_t  : fifo empty/full flags as seen by producers/consumers
//   isr_state_e    : ISR control states (IDLE, WAIT)
//   SHIFT_LEFT/SHIFT_RIGHT : shift direction encodings
//   decode_count() : turns a count field where 0 means "full width" into a bit count
package input_shift_register_pkg;

  localparam int ISR_WIDTH = 32;

  typedef struct packed {
    logic empty;
    logic full;
  } fifo_status_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } isr_state_e;

  localparam logic SHIFT_LEFT  = 1'b0;
  localparam logic SHIFT_RIGHT = 1'b1;

  // A zero count field cannot mean "shift nothing" (the instruction would be
  // pointless), so it is reused to encode the full register width.
  function automatic int decode_count(input int field, input int width);
    return (field == 0) ? width : field;
  endfunction

endpackage

// File: rtl/input_shift_register_if.sv
// RX fifo write-side interface between the ISR and the receive fifo.
//   fifo_data : word written into the fifo (ISR drives)
//   fifo_push : one-cycle push strobe (ISR drives)
//   status    : fifo empty/full flags (fifo drives)
// master = ISR side, slave = fifo side.
interface input_shift_register_if
  import input_shift_register_pkg::*;
#(
  parameter int WIDTH = ISR_WIDTH
) ();

  logic [WIDTH-1:0] fifo_data;
  logic             fifo_push;
  fifo_status_t     status;

  modport master (
    output fifo_data,
    output fifo_push,
    input  status
  );

  modport slave (
    input  fifo_data,
    input  fifo_push,
    output status
  );

endinterface

// File: rtl/input_shift_register_isr_shift_merge.sv
// Combinational shift/merge of new pin bits into a shift register word.
// Shared by the input and output shift registers.
//   isr     : current register contents
//   in_data : source bits; only in_data[n-1:0] are used
//   n       : number of bits to shift, 1..WIDTH
//   dir     : SHIFT_RIGHT (new bits enter at MSB) or SHIFT_LEFT (enter at LSB)
//   shifted : resulting word
module input_shift_register_isr_shift_merge
  import input_shift_register_pkg::*;
#(
  parameter  int WIDTH = ISR_WIDTH,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] isr,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] n,
  input  logic             dir,
  output logic [WIDTH-1:0] shifted
);

  logic [CNT_W-1:0] fill_pos;
  logic [WIDTH-1:0] keep_mask;

  // Shifts by the full width legitimately yield zero, which makes n=WIDTH
  // collapse to "replace with in_data" without a special case.
  always_comb begin
    fill_pos  = CNT_W'(WIDTH) - n;
    keep_mask = ~({WIDTH{1'b1}} << n);
    shifted   = isr;
    case (dir)
      SHIFT_RIGHT: shifted = (isr >> n) | (in_data << fill_pos);
      SHIFT_LEFT:  shifted = (isr << n) | (in_data & keep_mask);
    endcase
  end

endmodule

// File: rtl/input_shift_register.sv
// Per-FSM input shift register (ISR). Shifts GPIO samples in on IN
// instructions and pushes full words into the RX fifo, either by an explicit
// PUSH or by autopush once the shift count reaches the threshold. While a
// push is waiting for fifo space the FSM is stalled.
// Ports:
//   clk, rst                   : clock (rising edge), async active-low reset
//   in_data                    : pin sample bus
//   shift_en/shift_count/shiftdir : IN instruction (count 0 = WIDTH)
//   autopush/push_thresh       : autopush enable and threshold (0 = WIDTH)
//   push_req/push_block        : PUSH instruction and its blocking flag
//   mov/mov_in/mov_out         : MOV into/out of the ISR
//   isr, input_shift_counter   : current contents and bit count
//   stall                      : FSM must hold its PC
//   fifo                       : RX fifo write side (master modport)
// Build option: define ISR_MOV_EN to enable MOV loads (mov=01) and mov_out.
module input_shift_register
  import input_shift_register_pkg::*;
#(
  parameter  int WIDTH   = ISR_WIDTH,
  localparam int CNT_W   = $clog2(WIDTH) + 1,
  localparam int FIELD_W = $clog2(WIDTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    in_data,
  input  logic                shift_en,
  input  logic [FIELD_W-1:0]  shift_count,
  input  logic                shiftdir,
  input  logic                autopush,
  input  logic [FIELD_W-1:0]  push_thresh,
  input  logic                push_req,
  input  logic                push_block,
  input  logic [WIDTH-1:0]    mov_in,
  input  logic [1:0]          mov,
  output logic [WIDTH-1:0]    mov_out,
  output logic [WIDTH-1:0]    isr,
  output logic                stall,
  output logic [CNT_W-1:0]    input_shift_counter,
  input_shift_register_if.master fifo
);

  isr_state_e       state_q, state_d;
  logic [WIDTH-1:0] isr_q, isr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             push_q, push_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] shift_n, thresh_n, cnt_sat;
  logic [CNT_W:0]   cnt_sum;
  logic [WIDTH-1:0] shifted;
  logic             fifo_full;
  logic             mov_load;
  logic             unused_status;

  assign fifo_full     = fifo.status.full;
  assign unused_status = fifo.status.empty;

`ifdef ISR_MOV_EN
  assign mov_load = (mov == 2'b01);
  assign mov_out  = isr_q;
`else
  logic unused_mov;
  assign mov_load   = 1'b0;
  assign mov_out    = '0;
  assign unused_mov = ^{mov, mov_in};
`endif

  assign shift_n  = CNT_W'(decode_count(int'(shift_count), WIDTH));
  assign thresh_n = CNT_W'(decode_count(int'(push_thresh), WIDTH));

  input_shift_register_isr_shift_merge #(.WIDTH(WIDTH)) u_merge (
    .isr     (isr_q),
    .in_data (in_data),
    .n       (shift_n),
    .dir     (shiftdir),
    .shifted (shifted)
  );

  // The counter saturates at WIDTH so that autopush with a threshold below
  // the current count still fires, and so it never wraps when autopush is off.
  always_comb begin
    cnt_sum = {1'b0, cnt_q} + {1'b0, shift_n};
    cnt_sat = (cnt_sum > (CNT_W + 1)'(WIDTH)) ? CNT_W'(WIDTH) : cnt_sum[CNT_W-1:0];
  end

  // Next-state logic. In IDLE only the highest-priority request is honoured
  // (push, then mov, then shift). A push that cannot complete because the
  // fifo is full parks in WAIT holding the word, and leaves on the first
  // cycle the fifo has room, pushing that held word.
  always_comb begin
    state_d = state_q;
    isr_d   = isr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    push_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (push_req) begin
          if (!fifo_full) begin
            data_d = isr_q;
            push_d = 1'b1;
            isr_d  = '0;
            cnt_d  = '0;
          end else if (push_block) begin
            state_d = WAIT;
          end else begin
            isr_d = '0;
            cnt_d = '0;
          end
        end else if (mov_load) begin
          isr_d = mov_in;
          cnt_d = '0;
        end else if (shift_en) begin
          if (autopush && (cnt_sat >= thresh_n)) begin
            if (!fifo_full) begin
              data_d = shifted;
              push_d = 1'b1;
              isr_d  = '0;
              cnt_d  = '0;
            end else begin
              isr_d   = shifted;
              cnt_d   = cnt_sat;
              state_d = WAIT;
            end
          end else begin
            isr_d = shifted;
            cnt_d = cnt_sat;
          end
        end
      end
      WAIT: begin
        if (!fifo_full) begin
          data_d  = isr_q;
          push_d  = 1'b1;
          isr_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any pending push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      isr_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      push_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      isr_q   <= isr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      push_q  <= push_d;
    end
  end

  assign isr                 = isr_q;
  assign input_shift_counter = cnt_q;
  assign stall               = (state_q == WAIT);
  assign fifo.fifo_data      = data_q;
  assign fifo.fifo_push      = push_q;

endmodule

// File: tb/tb_input_shift_register.sv
// Testbench for input_shift_register: a table of directed vectors, a few
// hand-written multi-cycle sequences (MOV priority, async reset), then
// randomized stimulus checked against a bit-level reference model.
module tb_input_shift_register;
  import input_shift_register_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        shift_en;
  logic [4:0]  shift_count;
  logic        shiftdir;
  logic        autopush;
  logic [4:0]  push_thresh;
  logic        push_req;
  logic        push_block;
  logic [31:0] mov_in;
  logic [1:0]  mov;
  logic [31:0] mov_out;
  logic [31:0] isr;
  logic        stall;
  logic [5:0]  input_shift_counter;

  input_shift_register_if #(.WIDTH(32)) fifo_if ();

  input_shift_register #(.WIDTH(32)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .in_data             (in_data),
    .shift_en            (shift_en),
    .shift_count         (shift_count),
    .shiftdir            (shiftdir),
    .autopush            (autopush),
    .push_thresh         (push_thresh),
    .push_req            (push_req),
    .push_block          (push_block),
    .mov_in              (mov_in),
    .mov                 (mov),
    .mov_out             (mov_out),
    .isr                 (isr),
    .stall               (stall),
    .input_shift_counter (input_shift_counter),
    .fifo                (fifo_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        shift_en;
    logic [4:0]  shift_count;
    logic        shiftdir;
    logic        autopush;
    logic [4:0]  push_thresh;
    logic        push_req;
    logic        push_block;
    logic        fifo_full;
    logic [31:0] in_data;
    logic [1:0]  mov;
    logic [31:0] mov_in;
  } vec_in_t;

  typedef struct {
    logic [31:0] isr;
    logic [5:0]  cnt;
    logic        push;
    logic [31:0] data;
    logic        stall;
  } vec_out_t;

  typedef struct {
    vec_in_t  stim;
    vec_out_t resp;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [31:0] m_isr;
  int          m_cnt;
  bit          m_wait;
  bit          m_push;
  logic [31:0] m_data;

  function automatic vec_in_t mk_in(int se, int cnt, int dir, int ap, int th,
                                    int pr, int pb, int full, logic [31:0] din);
    vec_in_t v;
    v.shift_en    = 1'(se);
    v.shift_count = 5'(cnt);
    v.shiftdir    = 1'(dir);
    v.autopush    = 1'(ap);
    v.push_thresh = 5'(th);
    v.push_req    = 1'(pr);
    v.push_block  = 1'(pb);
    v.fifo_full   = 1'(full);
    v.in_data     = din;
    v.mov         = 2'b00;
    v.mov_in      = 32'h0;
    return v;
  endfunction

  function automatic vec_out_t mk_out(logic [31:0] e_isr, int e_cnt, int e_push,
                                      logic [31:0] e_data, int e_stall);
    vec_out_t r;
    r.isr   = e_isr;
    r.cnt   = 6'(e_cnt);
    r.push  = 1'(e_push);
    r.data  = e_data;
    r.stall = 1'(e_stall);
    return r;
  endfunction

  function automatic vec_t mk(int se, int cnt, int dir, int ap, int th, int pr,
                              int pb, int full, logic [31:0] din,
                              logic [31:0] e_isr, int e_cnt, int e_push,
                              logic [31:0] e_data, int e_stall);
    vec_t v;
    v.stim = mk_in(se, cnt, dir, ap, th, pr, pb, full, din);
    v.resp = mk_out(e_isr, e_cnt, e_push, e_data, e_stall);
    return v;
  endfunction

  task automatic apply_stimulus(input vec_in_t v);
    shift_en             = v.shift_en;
    shift_count          = v.shift_count;
    shiftdir             = v.shiftdir;
    autopush             = v.autopush;
    push_thresh          = v.push_thresh;
    push_req             = v.push_req;
    push_block           = v.push_block;
    in_data              = v.in_data;
    mov                  = v.mov;
    mov_in               = v.mov_in;
    fifo_if.status.full  = v.fifo_full;
    fifo_if.status.empty = 1'b0;
  endtask

  task automatic clock_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input vec_out_t e);
    logic [31:0] e_mov_out;
`ifdef ISR_MOV_EN
    e_mov_out = e.isr;
`else
    e_mov_out = 32'h0;
`endif
    vectors++;
    if (isr !== e.isr) begin
      miscompares++;
      $display("[TB] FAIL %s isr: got %08h expected %08h", name, isr, e.isr);
    end
    if (input_shift_counter !== e.cnt) begin
      miscompares++;
      $display("[TB] FAIL %s counter: got %0d expected %0d", name, input_shift_counter, e.cnt);
    end
    if (fifo_if.fifo_push !== e.push) begin
      miscompares++;
      $display("[TB] FAIL %s fifo_push: got %0b expected %0b", name, fifo_if.fifo_push, e.push);
    end
    if (e.push && (fifo_if.fifo_data !== e.data)) begin
      miscompares++;
      $display("[TB] FAIL %s fifo_data: got %08h expected %08h", name, fifo_if.fifo_data, e.data);
    end
    if (stall !== e.stall) begin
      miscompares++;
      $display("[TB] FAIL %s stall: got %0b expected %0b", name, stall, e.stall);
    end
    if (mov_out !== e_mov_out) begin
      miscompares++;
      $display("[TB] FAIL %s mov_out: got %08h expected %08h", name, mov_out, e_mov_out);
    end
  endtask

  task automatic model_reset();
    m_isr  = 32'h0;
    m_cnt  = 0;
    m_wait = 1'b0;
    m_push = 1'b0;
    m_data = 32'h0;
  endtask

  // Predicts the ISR after one clock edge. Shifts are computed on a 64-bit
  // concatenation: {new, old} >> n for right, (old << n) | new-bits for left.
  task automatic model_step(input vec_in_t v);
    int          n;
    int          t;
    int          c;
    logic [63:0] cat;
    logic [31:0] sh;
    n = (v.shift_count == 5'd0) ? 32 : int'(v.shift_count);
    t = (v.push_thresh == 5'd0) ? 32 : int'(v.push_thresh);
    m_push = 1'b0;
    if (m_wait) begin
      if (!v.fifo_full) begin
        m_data = m_isr;
        m_push = 1'b1;
        m_isr  = 32'h0;
        m_cnt  = 0;
        m_wait = 1'b0;
      end
    end else if (v.push_req) begin
      if (!v.fifo_full) begin
        m_data = m_isr;
        m_push = 1'b1;
        m_isr  = 32'h0;
        m_cnt  = 0;
      end else if (v.push_block) begin
        m_wait = 1'b1;
      end else begin
        m_isr = 32'h0;
        m_cnt = 0;
      end
    end
`ifdef ISR_MOV_EN
    else if (v.mov == 2'b01) begin
      m_isr = v.mov_in;
      m_cnt = 0;
    end
`endif
    else if (v.shift_en) begin
      if (v.shiftdir) begin
        cat = {v.in_data, m_isr} >> n;
      end else begin
        cat = ({32'h0, m_isr} << n) | ({32'h0, v.in_data} & ((64'h1 << n) - 64'h1));
      end
      sh = cat[31:0];
      c  = (m_cnt + n > 32) ? 32 : m_cnt + n;
      if (v.autopush && c >= t) begin
        if (!v.fifo_full) begin
          m_data = sh;
          m_push = 1'b1;
          m_isr  = 32'h0;
          m_cnt  = 0;
        end else begin
          m_isr  = sh;
          m_cnt  = c;
          m_wait = 1'b1;
        end
      end else begin
        m_isr = sh;
        m_cnt = c;
      end
    end
  endtask

  initial begin
    vec_t     vec_q[$];
    vec_in_t  v;
    vec_out_t e;

    rst = 1'b0;
    apply_stimulus(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
    clock_step();
    clock_step();
    check_output("reset", mk_out(32'h0, 0, 0, 32'h0, 0));
    vectors++;
    if (fifo_if.fifo_data !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset fifo_data: got %08h expected 00000000", fifo_if.fifo_data);
    end
    rst = 1'b1;

    // se cnt dir ap th pr pb full din | isr cnt push data stall
    vec_q.push_back(mk(1, 8, 0, 1, 0, 0, 0, 0, 32'hA5, 32'h000000A5, 8, 0, 0, 0));
    vec_q.push_back(mk(1, 8, 0, 1, 0, 0, 0, 0, 32'hA5, 32'h0000A5A5, 16, 0, 0, 0));
    vec_q.push_back(mk(1, 8, 0, 1, 0, 0, 0, 0, 32'hA5, 32'h00A5A5A5, 24, 0, 0, 0));
    vec_q.push_back(mk(1, 8, 0, 1, 0, 0, 0, 0, 32'hA5, 32'h0, 0, 1, 32'hA5A5A5A5, 0));
    vec_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0));
    vec_q.push_back(mk(1, 4, 1, 0, 0, 0, 0, 0, 32'hF, 32'hF0000000, 4, 0, 0, 0));
    vec_q.push_back(mk(1, 4, 1, 0, 0, 0, 0, 0, 32'hF, 32'hFF000000, 8, 0, 0, 0));
    vec_q.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 32'h12345678, 32'h12345678, 32, 0, 0, 0));
    vec_q.push_back(mk(1, 4, 0, 0, 0, 0, 0, 0, 32'hFFFFFFF3, 32'h23456783, 32, 0, 0, 0));
    vec_q.push_back(mk(1, 8, 0, 0, 0, 1, 0, 0, 32'hFF, 32'h0, 0, 1, 32'h23456783, 0));
    vec_q.push_back(mk(1, 8, 0, 0, 0, 0, 0, 0, 32'h5A, 32'h5A, 8, 0, 0, 0));
    vec_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 32'h0, 32'h0, 0, 0, 0, 0));
    vec_q.push_back(mk(1, 8, 0, 0, 0, 0, 0, 0, 32'h77, 32'h77, 8, 0, 0, 0));
    vec_q.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 32'h0, 32'h77, 8, 0, 0, 1));
    vec_q.push_back(mk(1, 8, 0, 0, 0, 1, 1, 1, 32'hEE, 32'h77, 8, 0, 0, 1));
    vec_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 32'h77, 0));
    vec_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0));
    vec_q.push_back(mk(1, 8, 0, 1, 16, 0, 0, 1, 32'h11, 32'h11, 8, 0, 0, 0));
    vec_q.push_back(mk(1, 8, 0, 1, 16, 0, 0, 1, 32'h22, 32'h1122, 16, 0, 0, 1));
    vec_q.push_back(mk(0, 0, 0, 1, 16, 0, 0, 1, 32'h0, 32'h1122, 16, 0, 0, 1));
    vec_q.push_back(mk(0, 0, 0, 1, 16, 0, 0, 0, 32'h0, 32'h0, 0, 1, 32'h1122, 0));
    vec_q.push_back(mk(0, 0, 0, 1, 16, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0));

    foreach (vec_q[i]) begin
      apply_stimulus(vec_q[i].stim);
      clock_step();
      check_output($sformatf("table[%0d]", i), vec_q[i].resp);
    end

    // MOV has priority over a simultaneous shift; reserved encodings do nothing
    apply_stimulus(mk_in(1, 8, 0, 0, 0, 0, 0, 0, 32'h3C));
    clock_step();
    check_output("mov_pre", mk_out(32'h3C, 8, 0, 0, 0));
    v = mk_in(1, 8, 0, 0, 0, 0, 0, 0, 32'h11);
    v.mov    = 2'b01;
    v.mov_in = 32'hDEADBEEF;
    apply_stimulus(v);
    clock_step();
`ifdef ISR_MOV_EN
    e = mk_out(32'hDEADBEEF, 0, 0, 0, 0);
`else
    e = mk_out(32'h3C11, 16, 0, 0, 0);
`endif
    check_output("mov_load", e);
    v = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    v.mov    = 2'b10;
    v.mov_in = 32'h1;
    apply_stimulus(v);
    clock_step();
    check_output("mov_reserved", e);

    // Asynchronous reset while stalled in WAIT
    apply_stimulus(mk_in(0, 0, 0, 0, 0, 1, 0, 1, 32'h0));
    clock_step();
    check_output("discard", mk_out(32'h0, 0, 0, 0, 0));
    apply_stimulus(mk_in(1, 8, 0, 0, 0, 0, 0, 0, 32'h99));
    clock_step();
    apply_stimulus(mk_in(0, 0, 0, 0, 0, 1, 1, 1, 32'h0));
    clock_step();
    check_output("enter_wait", mk_out(32'h99, 8, 0, 0, 1));
    #2 rst = 1'b0;
    #1 check_output("async_reset_wait", mk_out(32'h0, 0, 0, 0, 0));
    clock_step();
    rst = 1'b1;
    apply_stimulus(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
    clock_step();
    check_output("after_reset_idle", mk_out(32'h0, 0, 0, 0, 0));

    // Asynchronous reset kills a push strobe mid-cycle
    apply_stimulus(mk_in(1, 8, 0, 0, 0, 0, 0, 0, 32'h42));
    clock_step();
    apply_stimulus(mk_in(0, 0, 0, 0, 0, 1, 0, 0, 32'h0));
    clock_step();
    check_output("push_strobe", mk_out(32'h0, 0, 1, 32'h42, 0));
    #2 rst = 1'b0;
    #1 check_output("async_reset_push", mk_out(32'h0, 0, 0, 0, 0));
    clock_step();
    rst = 1'b1;

    // Randomized stimulus against the reference model
    model_reset();
    for (int k = 0; k < 600; k++) begin
      v.shift_en    = 1'($urandom);
      v.shift_count = 5'($urandom);
      v.shiftdir    = 1'($urandom);
      v.autopush    = ($urandom_range(3) != 0);
      v.push_thresh = 5'($urandom);
      v.push_req    = ($urandom_range(7) == 0);
      v.push_block  = 1'($urandom);
      v.fifo_full   = ($urandom_range(3) == 0);
      v.in_data     = $urandom;
      v.mov         = ($urandom_range(7) == 0) ? 2'($urandom) : 2'b00;
      v.mov_in      = $urandom;
      apply_stimulus(v);
      model_step(v);
      clock_step();
      check_output($sformatf("random[%0d]", k),
                   mk_out(m_isr, m_cnt, int'(m_push), m_data, int'(m_wait)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
